// File: rtl/button_debounce_sync_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN (abort counter).
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_CNT_WIDTH     = 20;
    localparam int DEF_STABLE_CYCLES = 500000;
    localparam int GLITCH_W          = 8;

endpackage

// File: rtl/button_debounce_sync_if.sv
// Pad-side bundle of the debouncer: raw level in, clean level out.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt.
interface button_debounce_sync_if;
    import debounce_pkg::*;

    logic raw_in;
    logic clean;
    logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output raw_in,
        input  clean,
        input  busy,
        input  glitch_cnt
    );

    modport slave (
        input  raw_in,
        output clean,
        output busy,
        output glitch_cnt
    );
`else
    modport master (
        output raw_in,
        input  clean,
        input  busy
    );

    modport slave (
        input  raw_in,
        output clean,
        output busy
    );
`endif

endinterface

// File: rtl/button_debounce_sync_sync_chain.sv
// Multi-flop synchroniser for asynchronous pad inputs.
// Clears to 0 on the asynchronous active-low reset.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    // Shift the pad level through the chain, oldest sample at the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce_sync.sv
// Pushbutton conditioner: synchroniser plus stable-time qualifier FSM.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN (saturating abort count).
module button_debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    button_debounce_sync_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] LAST =
        CNT_WIDTH'(STABLE_CYCLES - 1);

    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nx;
    logic                 sync_in;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.raw_in),
        .q     (sync_in)
    );

    // State and stability counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Qualify each level change; any disagreement during a wait aborts it.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            LOW: begin
                if (sync_in) begin
                    state_nx = WAIT_HIGH;
                    cnt_nx   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_in) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_WIDTH'(1);
                end
            end
            HIGH: begin
                if (!sync_in) begin
                    state_nx = WAIT_LOW;
                    cnt_nx   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nx = LOW;
                cnt_nx   = '0;
            end
        endcase
    end

    // The encoding puts clean in bit 1 and busy in bit 0, so both
    // outputs come straight off state flops and cannot glitch.
    assign bus.clean = state[1];
    assign bus.busy  = state[0];

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                abort;
    logic [GLITCH_W-1:0] glitch_q;

    assign abort = ((state == WAIT_HIGH) && !sync_in) ||
                   ((state == WAIT_LOW)  &&  sync_in);

    // Count aborted qualifications, holding at the top value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q <= '0;
        end else if (abort && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_button_debounce_sync.sv
// Randomised and directed bench for button_debounce_sync.
// Two instances: STABLE_CYCLES=4 and STABLE_CYCLES=1.
module tb_button_debounce_sync;

    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic raw = 1'b0;

    int checks = 0;
    int passed = 0;

    bit m_clean [2];
    int m_run   [2];
    int m_gl    [2];
    int stab    [2] = '{4, 1};
    bit hist    [$];

    button_debounce_sync_if bus0 ();
    button_debounce_sync_if bus1 ();

    assign bus0.raw_in = raw;
    assign bus1.raw_in = raw;

    button_debounce_sync #(
        .SYNC_STAGES   (2),
        .CNT_WIDTH     (3),
        .STABLE_CYCLES (4)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    button_debounce_sync #(
        .SYNC_STAGES   (2),
        .CNT_WIDTH     (3),
        .STABLE_CYCLES (1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] mexp();
        return {m_clean[0], m_run[0] > 0, m_clean[1], m_run[1] > 0};
    endfunction

    function automatic logic [3:0] got();
        return {bus0.clean, bus0.busy, bus1.clean, bus1.busy};
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int d = 0; d < 2; d++) begin
            m_clean[d] = 1'b0;
            m_run[d]   = 0;
            m_gl[d]    = 0;
        end
    endtask

    // The debouncer sees the pad level SS edges late; clean flips once the
    // delayed level has disagreed with it on STABLE+1 consecutive edges.
    task automatic step();
        bit seen;
        @(posedge clk);
        hist.push_back(raw);
        if (hist.size() > 8) void'(hist.pop_front());
        seen = (hist.size() > SS) ? hist[hist.size() - 1 - SS] : 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (seen != m_clean[d]) begin
                m_run[d]++;
                if (m_run[d] == stab[d] + 1) begin
                    m_clean[d] = seen;
                    m_run[d]   = 0;
                end
            end else begin
                if (m_run[d] > 0 && m_gl[d] < 255) m_gl[d]++;
                m_run[d] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        raw = 1'b0;
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got() !== 4'b0000)
            $display("FAIL reset_state got=%b exp=0000", got());
        else passed++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checks++;
        if (bus0.glitch_cnt !== 8'd0 || bus1.glitch_cnt !== 8'd0)
            $display("FAIL reset_glitch got=%0d/%0d exp=0",
                     bus0.glitch_cnt, bus1.glitch_cnt);
        else passed++;
`endif
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (got() !== mexp())
                $display("FAIL idle i=%0d got=%b exp=%b", i, got(), mexp());
            else passed++;
        end
    endtask

    task automatic test_rise();
        logic [3:0] fixed;
        raw = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            fixed = {e >= 7, e >= 3 && e < 7, e >= 4, e == 3};
            checks++;
            if (got() !== fixed || got() !== mexp())
                $display("FAIL rise e=%0d got=%b exp=%b model=%b",
                         e, got(), fixed, mexp());
            else passed++;
        end
    endtask

    task automatic test_fall();
        logic [3:0] fixed;
        raw = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            fixed = {e < 7, e >= 3 && e < 7, e < 4, e == 3};
            checks++;
            if (got() !== fixed || got() !== mexp())
                $display("FAIL fall e=%0d got=%b exp=%b model=%b",
                         e, got(), fixed, mexp());
            else passed++;
        end
    endtask

    task automatic test_bounce();
        bit pat [16] = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int g0 = m_gl[0];
        for (int i = 0; i < 16; i++) begin
            raw = pat[i];
            step();
            checks++;
            if (bus0.clean !== 1'b0 || got() !== mexp())
                $display("FAIL bounce i=%0d got=%b exp=%b",
                         i, got(), mexp());
            else passed++;
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checks++;
        if (int'(bus0.glitch_cnt) !== g0 + 2)
            $display("FAIL bounce_glitch got=%0d exp=%0d",
                     bus0.glitch_cnt, g0 + 2);
        else passed++;
`else
        g0 = g0 + 0;
`endif
    endtask

    task automatic test_reset_mid();
        raw = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        checks++;
        if (bus0.busy !== 1'b1 || bus0.clean !== 1'b0)
            $display("FAIL mid_wait busy=%b clean=%b exp 1 0",
                     bus0.busy, bus0.clean);
        else passed++;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (got() !== 4'b0000)
            $display("FAIL mid_reset got=%b exp=0000", got());
        else passed++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checks++;
        if (bus0.glitch_cnt !== 8'd0)
            $display("FAIL mid_glitch got=%0d exp=0", bus0.glitch_cnt);
        else passed++;
`endif
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (bus0.clean !== (e >= 7) || got() !== mexp())
                $display("FAIL mid_release e=%0d got=%b exp=%b",
                         e, got(), mexp());
            else passed++;
        end
        raw = 1'b0;
        for (int e = 0; e < 8; e++) step();
    endtask

    task automatic test_glitch_sat();
        for (int p = 0; p < 300; p++) begin
            raw = 1'b1;
            step();
            raw = 1'b0;
            step();
            step();
            checks++;
            if (bus0.clean !== 1'b0 || bus1.clean !== 1'b0 ||
                got() !== mexp())
                $display("FAIL glitch p=%0d got=%b exp=%b",
                         p, got(), mexp());
            else passed++;
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checks++;
        if (bus0.glitch_cnt !== 8'd255 || bus1.glitch_cnt !== 8'd255)
            $display("FAIL glitch_sat got=%0d/%0d exp=255",
                     bus0.glitch_cnt, bus1.glitch_cnt);
        else passed++;
`endif
    endtask

    task automatic test_random();
        int hold;
        reset = 1'b0;
        model_clear();
        #3;
        reset = 1'b1;
        for (int n = 0; n < 120; n++) begin
            raw = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 10);
            for (int h = 0; h < hold; h++) begin
                step();
                checks++;
                if (got() !== mexp())
                    $display("FAIL random n=%0d got=%b exp=%b",
                             n, got(), mexp());
                else passed++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                checks++;
                if (int'(bus0.glitch_cnt) !== m_gl[0] ||
                    int'(bus1.glitch_cnt) !== m_gl[1])
                    $display("FAIL random_glitch got=%0d/%0d exp=%0d/%0d",
                             bus0.glitch_cnt, bus1.glitch_cnt,
                             m_gl[0], m_gl[1]);
                else passed++;
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_bounce();
        test_reset_mid();
        test_glitch_sat();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/button_debounce_sync.md
Name: button_debounce_sync

Overview:
- Conditions a raw asynchronous input (pushbutton or switch) before it reaches the edge-detector stage.
- Synchronises the input into the clk domain, then filters bounce with a stable-time counter FSM.
- Output `clean` is a glitch-free level that drives the edge detector's `signal` input directly.
- `busy` flags that a transition is being qualified.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops; legal range 2..4.
- CNT_WIDTH, 20: width of the stability counter.
- STABLE_CYCLES, 500000: consecutive synchronised cycles at the new level required before `clean` changes. Legal range 1 ≤ STABLE_CYCLES ≤ 2^CNT_WIDTH−1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is sampled on clk.
- raw_in  input  1  unsynchronised input from the pad.
- clean  output  1  debounced level, registered.
- busy  output  1  1 while in WAIT_HIGH or WAIT_LOW, registered/decoded from state.

Behaviour:
- Reset (reset=0):
  - sync flops = 0, state = LOW, cnt = 0.
  - clean = 0, busy = 0 (and glitch_cnt = 0 when the optional feature is built).
- Synchroniser:
  - raw_in shifts through SYNC_STAGES flops.
  - sync_in is the last stage.
  - The FSM never sees raw_in directly.
- State machine, 2-bit encoding (LOW=0, WAIT_HIGH=1, HIGH=2, WAIT_LOW=3):
  - LOW: clean=0. If sync_in=1, go to WAIT_HIGH with cnt←0; else stay.
  - WAIT_HIGH: clean=0.
    - If sync_in=0, go to LOW with cnt←0 (abort/glitch).
    - Else if cnt==STABLE_CYCLES−1, go to HIGH with cnt←0.
    - Else cnt←cnt+1.
  - HIGH: clean=1. If sync_in=0, go to WAIT_LOW with cnt←0.
  - WAIT_LOW: clean=1.
    - If sync_in=1, go to HIGH with cnt←0 (abort/glitch).
    - Else if cnt==STABLE_CYCLES−1, go to LOW with cnt←0.
    - Else cnt←cnt+1.
- Illegal state: cannot occur with a 2-bit encoding of 4 states; the default branch returns to LOW with clean=0.
- Latency: a raw level held stable from the first sampling edge changes `clean` after exactly SYNC_STAGES+STABLE_CYCLES+1 rising edges.
- Glitch rule: any pulse on sync_in shorter than STABLE_CYCLES cycles never reaches `clean`.
- Counter:
  - Never wraps; it is compared for equality only and cleared on every state change.
  - cnt width is CNT_WIDTH; the comparison is against the truncated constant STABLE_CYCLES−1.
- STABLE_CYCLES=1: the WAIT state lasts exactly one cycle, i.e. one confirming sample.
- Reset mid-qualification: state, cnt and sync chain clear asynchronously with no output pulse.
  - After release with raw_in held 1, the normal latency applies from the first edge after release.
- `clean` changes at most once per STABLE_CYCLES+1 cycles, so the downstream edge detector sees a single rising edge per press.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds output `glitch_cnt`, output, 8 bits.
  - Increments on every WAIT_HIGH→LOW or WAIT_LOW→HIGH abort.
  - Saturates at 255; reset value 0; no other behaviour changes.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `debounce_pkg`:
  - 2-bit state typedef with the LOW/WAIT_HIGH/HIGH/WAIT_LOW constants.
  - Default STABLE_CYCLES and CNT_WIDTH constants.
- Sub-module `sync_chain`:
  - Parameterised SYNC_STAGES shift register with asynchronous active-low reset to 0.
  - Reusable for the other pad inputs.
- FSM and counter stay in the top module.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, CNT_WIDTH=3):
1. Reset pulse, then raw_in rises cleanly and holds → clean=0, busy=0 out of reset; busy=1 from edge 3; clean=1 exactly at edge 7 after the first sampling edge; busy=0 at the same edge.
2. With clean=1, raw_in drops and holds → clean=0 at edge 7; no intermediate toggles.
3. Bounce: raw_in 1 for 2 cycles, 0 for 1, 1 for 3, 0 and hold → clean stays 0 throughout; with DEBOUNCE_GLITCH_CNT_EN, glitch_cnt=2.
4. raw_in held 1; reset asserted asynchronously mid-clock while in WAIT_HIGH (cnt=2) → clean=0, busy=0 immediately; after release, clean=1 exactly 7 edges later.
5. 300 single-cycle glitches with DEBOUNCE_GLITCH_CNT_EN → glitch_cnt saturates at 255 and clean remains 0.
6. STABLE_CYCLES=1 build, raw_in step → clean changes at edge 4; a 1-cycle raw pulse produces a 1-cycle WAIT_HIGH and no clean change.
